// File: rtl/fifo_arb_sched.sv
// fifo_arb_sched: picks one non-empty FIFO per cycle and pops it into a
// registered valid/ready output stage.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   arb_en            allow new grants; the output stage still drains when low
//   fifo_empty        per-channel empty flags
//   fifo_rdata        per-channel head words, channel i at [i*DATA_W +: DATA_W]
//   ch_prio           per-channel priority, larger value wins
//   fifo_rd_en        one-hot pop strobe (combinational)
//   out_valid         output word valid (registered)
//   out_data          output word (registered)
//   out_ch            source channel of out_data (registered)
//   out_prio          priority of the source channel at grant time (registered)
//   out_ready         downstream accept
//   grant_cnt         grants since reset, wraps at 2^16
//
// Arbitration order: aged channels first, then highest ch_prio.
// Ties go round-robin from the channel after the last grant.

module fifo_arb_sched #(
    parameter int N_CH    = 8,
    parameter int DATA_W  = 32,
    parameter int PRIO_W  = 2,
    parameter int AGE_MAX = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arb_en,
    input  logic [N_CH-1:0]           fifo_empty,
    input  logic [N_CH*DATA_W-1:0]    fifo_rdata,
    input  logic [N_CH*PRIO_W-1:0]    ch_prio,
    output logic [N_CH-1:0]           fifo_rd_en,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(N_CH)-1:0]   out_ch,
    output logic [PRIO_W-1:0]         out_prio,
    input  logic                      out_ready,
    output logic [15:0]               grant_cnt
);

    localparam int CW = $clog2(N_CH);
    localparam int AW = $clog2(AGE_MAX + 1);
    localparam int KW = PRIO_W + 1;
    localparam logic [AW-1:0] AGE_LIM = AW'(AGE_MAX);

    logic [AW-1:0]     wait_cnt [N_CH];
    logic [CW-1:0]     last_grant;
    logic [N_CH-1:0]   cand;
    logic [KW-1:0]     key [N_CH];
    logic [KW-1:0]     best_key;
    logic [CW-1:0]     win;
    logic [CW-1:0]     idx;
    logic              win_found;
    logic              load;
    logic [DATA_W-1:0] win_data;
    logic [PRIO_W-1:0] win_prio;

    assign cand = ~fifo_empty;

    // Effective key: the aged flag sits above the configured priority, so
    // any aged channel outranks every non-aged one.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            key[i] = {wait_cnt[i] == AGE_LIM, ch_prio[i*PRIO_W +: PRIO_W]};
        end
    end

    always_comb begin
        best_key = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cand[i] && (key[i] > best_key)) begin
                best_key = key[i];
            end
        end
    end

    // Round-robin scan over the top group, starting just after last_grant.
    // CW-bit arithmetic wraps naturally because N_CH is a power of two.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = last_grant + CW'(k + 1);
            if (!win_found && cand[idx] && (key[idx] == best_key)) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    assign win_data = fifo_rdata[win*DATA_W +: DATA_W];
    assign win_prio = ch_prio[win*PRIO_W +: PRIO_W];

    // The stage can take a word when empty or when its word leaves this cycle.
    assign load = !rst && arb_en && win_found && (!out_valid || out_ready);

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            fifo_rd_en[i] = load && (win == CW'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            out_prio   <= '0;
            grant_cnt  <= '0;
            last_grant <= CW'(N_CH - 1);
            for (int i = 0; i < N_CH; i++) begin
                wait_cnt[i] <= '0;
            end
        end else begin
            if (load) begin
                out_valid  <= 1'b1;
                out_data   <= win_data;
                out_ch     <= win;
                out_prio   <= win_prio;
                last_grant <= win;
                grant_cnt  <= grant_cnt + 16'd1;
                for (int i = 0; i < N_CH; i++) begin
                    if ((win == CW'(i)) || fifo_empty[i]) begin
                        wait_cnt[i] <= '0;
                    end else if (wait_cnt[i] != AGE_LIM) begin
                        wait_cnt[i] <= wait_cnt[i] + AW'(1);
                    end
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_arb_sched.sv
// Scoreboard bench for fifo_arb_sched: queue-based FIFO bank model on the
// input side, expected words queued per scenario and checked on accept.

module tb_fifo_arb_sched;

    localparam int N  = 8;
    localparam int DW = 32;
    localparam int PW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            arb_en = 1'b1;
    logic            out_ready = 1'b1;
    logic [N-1:0]    fifo_empty = '1;
    logic [N*DW-1:0] fifo_rdata = '0;
    logic [N*PW-1:0] ch_prio = '0;
    logic [N-1:0]    fifo_rd_en;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [2:0]      out_ch;
    logic [PW-1:0]   out_prio;
    logic [15:0]     grant_cnt;

    typedef struct packed {
        logic [2:0]  ch;
        logic [31:0] data;
        logic [1:0]  prio;
    } exp_t;

    exp_t        expq[$];
    exp_t        e_mon;
    exp_t        e_bld;
    logic [31:0] fq[N][$];
    logic [31:0] stg[N][$];
    logic [31:0] t4[$];
    logic [31:0] t6[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          last_acc = 0;
    int          seq = 0;
    int          c0;
    logic [15:0] g0;
    logic [31:0] hold_w;

    always #5 clk = ~clk;

    fifo_arb_sched #(
        .N_CH(N), .DATA_W(DW), .PRIO_W(PW), .AGE_MAX(15)
    ) dut (
        .clk(clk), .rst(rst), .arb_en(arb_en),
        .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
        .ch_prio(ch_prio), .fifo_rd_en(fifo_rd_en),
        .out_valid(out_valid), .out_data(out_data),
        .out_ch(out_ch), .out_prio(out_prio),
        .out_ready(out_ready), .grant_cnt(grant_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_prio(input int ch, input int p);
        ch_prio[ch*PW +: PW] = 2'(p);
    endtask

    task automatic clr_prio();
        ch_prio = '0;
    endtask

    task automatic put(input int ch, input int n);
        logic [31:0] w;
        for (int k = 0; k < n; k++) begin
            w = {8'(ch), 24'(seq)};
            seq++;
            fq[ch].push_back(w);
            stg[ch].push_back(w);
        end
    endtask

    task automatic expect_ch(input int ch, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.ch   = 3'(ch);
            e.data = stg[ch].pop_front();
            e.prio = ch_prio[ch*PW +: PW];
            expq.push_back(e);
        end
    endtask

    task automatic wait_valid(input int budget);
        int t = 0;
        while (!out_valid && t < budget) begin
            step(1);
            t++;
        end
        chk("valid_timeout", 64'(out_valid), 64'd1);
    endtask

    task automatic wait_drain(input int budget);
        int t = 0;
        while (expq.size() != 0 && t < budget) begin
            step(1);
            t++;
        end
        chk("drain_timeout", 64'(expq.size()), 64'd0);
        step(2);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    // FIFO bank model: pop on the pre-edge strobe, present the new head
    // after the edge so the DUT never races its own sample.
    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (fifo_rd_en[i] && fq[i].size() != 0) begin
                void'(fq[i].pop_front());
            end
        end
        for (int i = 0; i < N; i++) begin
            fifo_empty[i] <= (fq[i].size() == 0);
            fifo_rdata[i*DW +: DW] <= (fq[i].size() != 0) ? fq[i][0] : '0;
        end
    end

    always @(negedge clk) begin
        chk("rd_legal",
            64'(((fifo_rd_en & fifo_empty) == '0) && $onehot0(fifo_rd_en)),
            64'd1);
        if (!rst && out_valid && out_ready) begin
            last_acc = cyc;
            chk("sb_nonempty", 64'(expq.size() != 0), 64'd1);
            if (expq.size() != 0) begin
                e_mon = expq.pop_front();
                chk("out_ch", 64'(out_ch), 64'(e_mon.ch));
                chk("out_data", 64'(out_data), 64'(e_mon.data));
                chk("out_prio", 64'(out_prio), 64'(e_mon.prio));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset and idle; a word arrives late in reset and must not be popped
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);
            chk("rst_gcnt", 64'(grant_cnt), 64'd0);
            chk("rst_data", 64'(out_data), 64'd0);
            chk("rst_ch", 64'(out_ch), 64'd0);
            chk("rst_prio", 64'(out_prio), 64'd0);
            if (i == 1) put(0, 1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_ch(0, 1);
        wait_drain(20);
        chk("gcnt_first", 64'(grant_cnt), 64'd1);

        // strict priority: ch2 drains before ch5
        set_prio(2, 3);
        set_prio(5, 1);
        put(2, 4);
        put(5, 3);
        expect_ch(2, 4);
        expect_ch(5, 3);
        wait_drain(40);
        chk("gcnt_prio", 64'(grant_cnt), 64'd8);

        // round-robin over equal priorities, one word per cycle
        pulse_rst();
        for (int i = 0; i < N; i++) set_prio(i, 2);
        for (int i = 0; i < N; i++) put(i, 1);
        put(0, 1);
        for (int i = 0; i < N; i++) expect_ch(i, 1);
        expect_ch(0, 1);
        wait_valid(10);
        c0 = cyc;
        step(7);
        chk("rr_gcnt8", 64'(grant_cnt), 64'd8);
        chk("rr_ch7", 64'(out_ch), 64'd7);
        wait_drain(30);
        chk("rr_rate", 64'(last_acc - c0), 64'd8);
        chk("rr_gcnt9", 64'(grant_cnt), 64'd9);

        // aging: ch7 wins every 16th grant against a busy ch0
        pulse_rst();
        clr_prio();
        set_prio(0, 3);
        put(0, 35);
        put(7, 2);
        expect_ch(0, 15);
        expect_ch(7, 1);
        expect_ch(0, 15);
        expect_ch(7, 1);
        expect_ch(0, 5);
        wait_drain(80);

        // backpressure: ch3 word held, no pops, pop resumes on accept
        clr_prio();
        set_prio(3, 1);
        out_ready = 1'b0;
        put(3, 3);
        hold_w = stg[3][0];
        expect_ch(3, 3);
        wait_valid(10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_ch", 64'(out_ch), 64'd3);
            chk("bp_data", 64'(out_data), 64'(hold_w));
            chk("bp_rd_en", 64'(fifo_rd_en), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_passthru", 64'(fifo_rd_en), 64'h08);
        wait_drain(20);

        // arb_en low with a full stage: word delivered, nothing more popped
        clr_prio();
        set_prio(1, 1);
        out_ready = 1'b0;
        put(1, 2);
        expect_ch(1, 2);
        wait_valid(10);
        arb_en = 1'b0;
        out_ready = 1'b1;
        g0 = grant_cnt;
        @(negedge clk);
        chk("en_rd_en", 64'(fifo_rd_en), 64'd0);
        step(1);
        chk("en_valid", 64'(out_valid), 64'd0);
        step(2);
        chk("en_valid2", 64'(out_valid), 64'd0);
        chk("en_gcnt", 64'(grant_cnt), 64'(g0));
        arb_en = 1'b1;
        wait_drain(20);

        // async reset with a held word; restart goes to lowest top channel
        clr_prio();
        set_prio(4, 2);
        set_prio(6, 2);
        set_prio(1, 1);
        out_ready = 1'b0;
        put(4, 3);
        put(6, 3);
        wait_valid(10);
        step(1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data", 64'(out_data), 64'd0);
        chk("arst_rd_en", 64'(fifo_rd_en), 64'd0);
        step(3);
        chk("arst_nopop", 64'(fq[4].size() + fq[6].size()), 64'd5);
        stg[4].delete();
        stg[6].delete();
        t4 = fq[4];
        t6 = fq[6];
        while (t4.size() + t6.size() != 0) begin
            if (t4.size() != 0) begin
                e_bld.ch = 3'd4;
                e_bld.data = t4.pop_front();
                e_bld.prio = 2'd2;
                expq.push_back(e_bld);
            end
            if (t6.size() != 0) begin
                e_bld.ch = 3'd6;
                e_bld.data = t6.pop_front();
                e_bld.prio = 2'd2;
                expq.push_back(e_bld);
            end
        end
        rst = 1'b0;
        out_ready = 1'b1;
        wait_drain(30);
        chk("arst_gcnt", 64'(grant_cnt), 64'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_arb_sched.md
# fifo_arb_sched

Scheduler that shares the single destination output port among the per-channel synchronous FIFOs in the SyncFIFO datapath. Each cycle it picks one non-empty FIFO by APB-configured priority, with round-robin tie-break and age-based anti-starvation, pops one word from it, and presents it on a registered valid/ready output stage. It sits between the FIFO bank (first-word-fall-through read side) and the destination channel driver, and is observed by the bound assertion module.

## Interface
- N_CH, 8, number of FIFO channels (power of 2, ≥2)
- DATA_W, 32, FIFO word width
- PRIO_W, 2, priority field width; larger value = higher priority
- AGE_MAX, 15, wait cycles before a channel is aged (1..255)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- arb_en  in  1  1 = new grants allowed; 0 = freeze grants, output stage still drains
- fifo_empty  in  N_CH  per-channel FIFO empty flag
- fifo_rdata  in  N_CH*DATA_W  per-channel head word (valid when not empty), channel i at [i*DATA_W +: DATA_W]
- ch_prio  in  N_CH*PRIO_W  per-channel priority from APB config registers
- fifo_rd_en  out  N_CH  one-hot pop strobe, combinational
- out_valid  out  1  output word valid (registered)
- out_data  out  DATA_W  output word (registered)
- out_ch  out  $clog2(N_CH)  source channel of out_data (registered)
- out_prio  out  PRIO_W  ch_prio of source at grant time (registered)
- out_ready  in  1  downstream accepts when out_valid & out_ready
- grant_cnt  out  16  total grants since reset, wraps at 2^16

## Operation
- Candidate set: channels with fifo_empty[i]=0.
- Effective priority: aged channels (wait_cnt == AGE_MAX) beat all non-aged; among non-aged, highest ch_prio wins.
- Tie-break within top group: round-robin starting at (last_grant+1) mod N_CH, searching upward with wrap.
- Load condition: load = arb_en & |candidates & (~out_valid | out_ready).
- On load: fifo_rd_en[g]=1 for winner g only; next edge out_data<=fifo_rdata[g], out_ch<=g, out_prio<=ch_prio[g], out_valid<=1, last_grant<=g, grant_cnt++.
- No load & out_valid & out_ready: out_valid<=0 next edge; out_data/out_ch/out_prio hold.
- out_valid & ~out_ready: all out_* hold stable, fifo_rd_en=0.
- Aging, per channel, updated only on load cycles: winner or empty channel -> wait_cnt<=0; other non-empty channel -> wait_cnt<=min(wait_cnt+1, AGE_MAX). Counters hold when no load. Width $clog2(AGE_MAX+1).
- ch_prio sampled combinationally in the arbitration cycle; changes take effect on the next arbitration.
- fifo_rd_en never asserted for an empty channel; never more than one bit set.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, out_prio=0, grant_cnt=0, all wait_cnt=0, last_grant=N_CH-1 (channel 0 first); fifo_rd_en=0 while rst=1.
- Latency: pop cycle T -> out_valid/out_data at T+1.
- Throughput: one word per cycle with out_ready held high.
- Backpressure: zero pops while stage full and out_ready=0; pop resumes in the same cycle out_ready rises (pass-through on accept).
- Reset mid-transfer: held word dropped, out_valid=0 immediately (async); FIFOs not popped during reset.
- arb_en falling with stage full: current word still delivered, no further pops.

## Test plan
- Reset/idle: rst high 3 cycles, all FIFOs empty -> out_valid=0, fifo_rd_en=0, grant_cnt=0, out_* zero throughout.
- Strict priority: ch2 prio 3, ch5 prio 1, both non-empty, out_ready=1 -> ch2 granted each cycle until empty, then ch5; out_ch=2,2,...,5.
- Round-robin: all 8 channels prio 2 and non-empty, out_ready=1 -> out_ch sequence 0,1,2,...,7,0; one word per cycle; grant_cnt=8 after 8 grants.
- Aging: ch7 prio 0, ch0 prio 3 continuously non-empty, AGE_MAX=15 -> ch7 granted on the 16th grant, its wait_cnt then returns to 0.
- Backpressure: word from ch3 loaded, out_ready=0 for 5 cycles -> out_data/out_ch=3 stable, fifo_rd_en=0; out_ready=1 -> accept and next pop in the same cycle.
- Async reset mid-stream: rst asserted between edges with out_valid=1 -> out_valid=0 before the next edge; after release first grant goes to the lowest-index highest-priority channel.
